// File: rtl/hgcal_input_quantizer.sv
// Serial sample quantizer for the hgcal_quant2 LogicNets network: maps each raw
// sample to a 2-bit code and packs one frame into the layer0 input vector.
module hgcal_input_quantizer #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned NUM_INPUTS = 48,
  parameter int unsigned T1         = 16,
  parameter int unsigned T2         = 64,
  parameter int unsigned T3         = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_WIDTH-1:0]     s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*NUM_INPUTS-1:0] m_data,
  output logic                    frame_err,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [IN_WIDTH-1:0] TH1 = IN_WIDTH'(T1);
  localparam logic [IN_WIDTH-1:0] TH2 = IN_WIDTH'(T2);
  localparam logic [IN_WIDTH-1:0] TH3 = IN_WIDTH'(T3);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic [IDX_W-1:0]        slot;
  logic [1:0]              code;
  logic                    accept;
  logic                    wr_en;
  logic                    err_next;
  logic                    consume;
  logic [2*NUM_INPUTS-1:0] data_q;

  always_comb begin
    if (s_data >= TH3) begin
      code = 2'd3;
    end else if (s_data >= TH2) begin
      code = 2'd2;
    end else if (s_data >= TH1) begin
      code = 2'd1;
    end else begin
      code = 2'd0;
    end
  end

  // A sample arriving while the held vector is consumed starts the next frame
  // at slot 0 in the same cycle, so there is no bubble between frames.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    slot       = idx;
    wr_en      = 1'b0;
    err_next   = 1'b0;
    consume    = 1'b0;
    s_ready    = 1'b1;
    m_valid    = 1'b0;
    accept     = 1'b0;

    case (state)
      FILL: begin
        s_ready = 1'b1;
      end
      HOLD: begin
        m_valid = 1'b1;
        s_ready = m_ready;
        slot    = '0;
        if (m_ready) begin
          consume    = 1'b1;
          state_next = FILL;
          idx_next   = '0;
        end
      end
    endcase

    accept = s_valid && s_ready;
    if (accept) begin
      if (s_last && (slot != LAST_IDX)) begin
        idx_next = '0;
        err_next = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (slot == LAST_IDX) begin
          state_next = HOLD;
          idx_next   = '0;
          err_next   = !s_last;
        end else begin
          idx_next = slot + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      data_q    <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      frame_err <= err_next;
      if (consume) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (wr_en && (slot == IDX_W'(i))) begin
          data_q[2*i +: 2] <= code;
        end
      end
    end
  end

  assign m_data = data_q;

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Scoreboard bench for hgcal_input_quantizer: a frame-level reference model
// predicts vectors, counters and framing errors; a monitor compares them.
module tb_hgcal_input_quantizer;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   s_data = '0;
  logic           s_last = 1'b0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [2*N-1:0] m_data;
  logic           frame_err;
  logic [15:0]    frame_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit mready_rand = 1'b0;

  bit             exp_hold = 1'b0;
  bit             exp_err = 1'b0;
  int             exp_idx = 0;
  logic [15:0]    exp_cnt = '0;
  logic [1:0]     slots [N];
  logic [2*N-1:0] exp_q [$];

  hgcal_input_quantizer #(
    .IN_WIDTH(W), .NUM_INPUTS(N), .T1(16), .T2(64), .T3(128)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] quant(input logic [W-1:0] s);
    if (s >= 128) return 2'd3;
    if (s >= 64)  return 2'd2;
    if (s >= 16)  return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [2*N-1:0] packSlots();
    logic [2*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[2*i +: 2] = slots[i];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances one frame position per accepted sample.
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      exp_hold = 1'b0;
      exp_err  = 1'b0;
      exp_idx  = 0;
      exp_cnt  = '0;
      exp_q.delete();
      for (int i = 0; i < N; i++) slots[i] = 2'd0;
    end else begin
      acc = s_valid && (!exp_hold || m_ready);
      exp_err = 1'b0;
      if (exp_hold && m_ready) begin
        exp_hold = 1'b0;
        exp_cnt  = exp_cnt + 16'd1;
      end
      if (acc) begin
        if (s_last && exp_idx < N-1) begin
          exp_idx = 0;
          exp_err = 1'b1;
        end else begin
          slots[exp_idx] = quant(s_data);
          if (exp_idx == N-1) begin
            exp_q.push_back(packSlots());
            exp_hold = 1'b1;
            exp_idx  = 0;
            exp_err  = !s_last;
          end else begin
            exp_idx++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("m_valid", 64'(m_valid), 64'(exp_hold));
      checkOutput("s_ready", 64'(s_ready), exp_hold ? 64'(m_ready) : 64'd1);
      checkOutput("frame_err", 64'(frame_err), 64'(exp_err));
      checkOutput("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
      if (m_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL m_data_unexpected: got %0h, expected no vector at %0t", m_data, $time);
        end else begin
          checkOutput("m_data", 64'(m_data), 64'(exp_q[0]));
          if (m_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mready_rand) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic applyStimulus(input logic [W-1:0] d, input bit last);
    bit done;
    int c;
    done = 1'b0;
    c = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!done && c < 200) begin
      @(posedge clk);
      done = (s_ready === 1'b1);
      c++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got no accept in %0d cycles, expected accept", c);
    end
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic sendFrame(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d, input bit last);
    applyStimulus(a, 1'b0);
    applyStimulus(b, 1'b0);
    applyStimulus(c, 1'b0);
    applyStimulus(d, last);
  endtask

  task automatic releaseFrame();
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int pos;
    bit last;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    checkOutput("reset_s_ready", 64'(s_ready), 64'd1);
    checkOutput("reset_m_valid", 64'(m_valid), 64'd0);
    checkOutput("reset_m_data", 64'(m_data), 64'd0);
    checkOutput("reset_frame_cnt", 64'(frame_cnt), 64'd0);

    $display("[TB] boundary codes");
    sendFrame(8'd0, 8'd16, 8'd100, 8'd200, 1'b1);
    checkOutput("t1_m_valid", 64'(m_valid), 64'd1);
    checkOutput("t1_m_data", 64'(m_data), 64'hE4);
    checkOutput("t1_frame_err", 64'(frame_err), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    releaseFrame();
    checkOutput("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    checkOutput("t1_m_valid_drop", 64'(m_valid), 64'd0);

    $display("[TB] threshold edges");
    sendFrame(8'd15, 8'd63, 8'd127, 8'd255, 1'b1);
    releaseFrame();
    sendFrame(8'd16, 8'd64, 8'd128, 8'd0, 1'b1);
    checkOutput("t2_m_data", 64'(m_data), 64'h39);

    $display("[TB] backpressure");
    s_valid = 1'b1;
    s_data  = 8'd200;
    s_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t3_s_ready", 64'(s_ready), 64'd0);
      checkOutput("t3_m_data_stable", 64'(m_data), 64'h39);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    s_valid = 1'b0;
    checkOutput("t3_frame_cnt", 64'(frame_cnt), 64'd3);
    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd2, 1'b0);
    applyStimulus(8'd3, 1'b1);
    checkOutput("t3_m_valid", 64'(m_valid), 64'd1);
    checkOutput("t3_slot0", 64'(m_data[1:0]), 64'd3);
    releaseFrame();

    $display("[TB] early last");
    applyStimulus(8'd5, 1'b0);
    applyStimulus(8'd9, 1'b1);
    checkOutput("t4_frame_err", 64'(frame_err), 64'd1);
    checkOutput("t4_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("t4_frame_err_pulse", 64'(frame_err), 64'd0);
    sendFrame(8'd0, 8'd0, 8'd0, 8'd255, 1'b1);
    checkOutput("t4_m_data", 64'(m_data), 64'hC0);
    releaseFrame();

    $display("[TB] missing last");
    sendFrame(8'd50, 8'd50, 8'd50, 8'd50, 1'b0);
    checkOutput("t5_m_valid", 64'(m_valid), 64'd1);
    checkOutput("t5_frame_err", 64'(frame_err), 64'd1);
    releaseFrame();

    $display("[TB] reset mid-frame and in hold");
    applyStimulus(8'd30, 1'b0);
    applyStimulus(8'd90, 1'b0);
    pulseReset();
    checkOutput("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("t6_s_ready", 64'(s_ready), 64'd1);
    sendFrame(8'd7, 8'd70, 8'd170, 8'd17, 1'b1);
    pulseReset();
    checkOutput("t6_hold_m_valid", 64'(m_valid), 64'd0);
    checkOutput("t6_hold_m_data", 64'(m_data), 64'd0);
    sendFrame(8'd200, 8'd200, 8'd200, 8'd200, 1'b1);
    checkOutput("t6_m_data", 64'(m_data), 64'hFF);
    releaseFrame();
    checkOutput("t6_frame_cnt_restart", 64'(frame_cnt), 64'd1);

    $display("[TB] randomized traffic");
    mready_rand = 1'b1;
    pos = 0;
    for (int k = 0; k < 400; k++) begin
      last = (pos == N-1);
      if ($urandom_range(0, 11) == 0) last = !last;
      applyStimulus(W'($urandom_range(0, 255)), last);
      if (last && pos < N-1) pos = 0;
      else if (pos == N-1) pos = 0;
      else pos++;
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    mready_rand = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
